cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller.sv | 153 +++++++++++++++
 tb/tb_cache_controller.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache, one 32-bit word per line.
// A single FSM walks INIT sweep, lookup, eviction and refill.
module cache_controller #(
    parameter int INDEX_BITS = 11,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [2:0] {
        INIT, IDLE, LOOKUP, WRITEBACK, REFILL, RESP
    } state_t;

    state_t                state_q;
    logic [INDEX_BITS-1:0] init_idx_q;
    logic [LINES-1:0]      valid_q;
    logic [LINES-1:0]      dirty_q;
    logic [TAG_BITS-1:0]   tag_q [LINES];
    logic [31:0]           data_q [LINES];

    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        ready_q;
    logic        mreq_q;
    logic        mwe_q;
    logic [31:0] maddr_q;
    logic [31:0] mwdata_q;
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    logic [INDEX_BITS-1:0] idx_d;
    logic [TAG_BITS-1:0]   tag_d;
    logic                  hit_d;
    logic                  unused;

    assign idx_d  = addr_q[INDEX_BITS+1:2];
    assign tag_d  = addr_q[INDEX_BITS+2 +: TAG_BITS];
    assign hit_d  = valid_q[idx_d] && (tag_q[idx_d] == tag_d);
    assign unused = ^{addr_q[1:0], cpu_addr[1:0]};

    assign cpu_rdata  = rdata_q;
    assign cpu_ready  = ready_q;
    assign busy       = (state_q != IDLE);
    assign mem_req    = mreq_q;
    assign mem_we     = mwe_q;
    assign mem_addr   = maddr_q;
    assign mem_wdata  = mwdata_q;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= INIT;
            init_idx_q   <= '0;
            ready_q      <= 1'b0;
            mreq_q       <= 1'b0;
            mwe_q        <= 1'b0;
            maddr_q      <= '0;
            mwdata_q     <= '0;
            rdata_q      <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            unique case (state_q)
                INIT: begin
                    valid_q[init_idx_q] <= 1'b0;
                    dirty_q[init_idx_q] <= 1'b0;
                    init_idx_q          <= init_idx_q + 1'b1;
                    if (&init_idx_q) state_q <= IDLE;
                end
                IDLE: begin
                    if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        we_q    <= cpu_we;
                        wdata_q <= cpu_wdata;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit_d) begin
                        hit_count_q <= hit_count_q + 32'd1;
                        if (we_q) begin
                            data_q[idx_d]  <= wdata_q;
                            dirty_q[idx_d] <= 1'b1;
                        end else begin
                            rdata_q <= data_q[idx_d];
                        end
                        ready_q <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        miss_count_q <= miss_count_q + 32'd1;
                        mreq_q       <= 1'b1;
                        if (valid_q[idx_d] && dirty_q[idx_d]) begin
                            mwe_q    <= 1'b1;
                            maddr_q  <= {tag_q[idx_d], idx_d, 2'b00};
                            mwdata_q <= data_q[idx_d];
                            state_q  <= WRITEBACK;
                        end else begin
                            mwe_q   <= 1'b0;
                            maddr_q <= {tag_d, idx_d, 2'b00};
                            state_q <= REFILL;
                        end
                    end
                end
                WRITEBACK: begin
                    // Refill request follows the victim write back-to-back
                    if (mem_ack) begin
                        mwe_q   <= 1'b0;
                        maddr_q <= {tag_d, idx_d, 2'b00};
                        state_q <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        mreq_q         <= 1'b0;
                        valid_q[idx_d] <= 1'b1;
                        dirty_q[idx_d] <= we_q;
                        tag_q[idx_d]   <= tag_d;
                        data_q[idx_d]  <= we_q ? wdata_q : mem_rdata;
                        if (!we_q) rdata_q <= mem_rdata;
                        ready_q        <= 1'b1;
                        state_q        <= RESP;
                    end
                end
                RESP: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Random and directed requests against a line-table model of the cache
// with a responding memory that logs every transaction.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    cache_controller dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    int n_vec = 0;
    int n_err = 0;

    txn_t        txq[$];
    logic [31:0] mem_store [logic [31:0]];
    int          mem_wait = 0;

    bit          m_valid [2048];
    bit          m_dirty [2048];
    logic [18:0] m_tag   [2048];
    logic [31:0] m_data  [2048];
    logic [31:0] m_hits;
    logic [31:0] m_miss;
    logic [31:0] m_rdata;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic void model_reset();
        foreach (m_valid[i]) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
        m_hits  = 0;
        m_miss  = 0;
        m_rdata = 0;
    endfunction

    // Memory: fixed wait per transaction, then a one-cycle ack
    initial begin
        txn_t cur;
        bit   in_txn;
        int   wleft;
        in_txn    = 0;
        wleft     = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        cur       = '{1'b0, 32'h0, 32'h0};
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req === 1'b1) begin
                if (!in_txn) begin
                    in_txn = 1;
                    wleft  = mem_wait;
                    cur    = '{mem_we, mem_addr, mem_wdata};
                    txq.push_back(cur);
                end else begin
                    chk("mem_addr_hold", mem_addr, cur.addr);
                    chk("mem_we_hold", {31'b0, mem_we}, {31'b0, cur.we});
                end
                if (wleft == 0) begin
                    mem_ack = 1'b1;
                    if (cur.we) mem_store[cur.addr] = cur.wdata;
                    else mem_rdata = mem_rd(cur.addr);
                    in_txn = 0;
                end else begin
                    wleft--;
                end
            end else begin
                in_txn = 0;
            end
        end
    end

    task automatic do_req(input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input int wt);
        logic [10:0] ix;
        logic [18:0] tg;
        logic [31:0] al;
        logic [31:0] rd;
        txn_t        exq[$];
        int          lat;
        int          cyc;
        ix = addr[12:2];
        tg = addr[31:13];
        al = {addr[31:2], 2'b00};
        if (m_valid[ix] && m_tag[ix] == tg) begin
            m_hits = m_hits + 1;
            if (we) begin
                m_data[ix]  = wd;
                m_dirty[ix] = 1;
            end else begin
                m_rdata = m_data[ix];
            end
        end else begin
            m_miss = m_miss + 1;
            if (m_valid[ix] && m_dirty[ix])
                exq.push_back('{1'b1, {m_tag[ix], ix, 2'b00}, m_data[ix]});
            exq.push_back('{1'b0, al, 32'h0});
            rd          = mem_rd(al);
            m_valid[ix] = 1;
            m_tag[ix]   = tg;
            m_dirty[ix] = we;
            m_data[ix]  = we ? wd : rd;
            if (!we) m_rdata = rd;
        end
        lat = 3 + exq.size() * (wt + 1);
        mem_wait = wt;
        txq.delete();
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (cpu_ready !== 1'b1 && cyc < 200);
        cpu_req = 1'b0;
        chk("cpu_ready", {31'b0, cpu_ready}, 32'd1);
        chk("latency", cyc + 1, lat);
        chk("cpu_rdata", cpu_rdata, m_rdata);
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_miss);
        chk("txn_count", txq.size(), exq.size());
        for (int i = 0; i < exq.size() && i < txq.size(); i++) begin
            chk("txn_we", {31'b0, txq[i].we}, {31'b0, exq[i].we});
            chk("txn_addr", txq[i].addr, exq[i].addr);
            if (exq[i].we) chk("txn_wdata", txq[i].wdata, exq[i].wdata);
        end
        @(negedge clk);
        chk("ready_pulse", {31'b0, cpu_ready}, 32'd0);
        chk("rdata_hold", cpu_rdata, m_rdata);
        chk("idle_busy", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int cnt;
        int pulses;
        bit req_seen;
        logic [31:0] a;
        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        model_reset();

        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, cpu_ready}, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_misses", miss_count, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd1);

        reset = 1'b0;
        cnt = 0;
        req_seen = 0;
        while (busy === 1'b1 && cnt < 5000) begin
            if (mem_req !== 1'b0) req_seen = 1;
            cnt++;
            @(negedge clk);
        end
        chk("init_cycles", cnt, 2048);
        chk("init_mem_req", {31'b0, req_seen}, 32'd0);
        chk("init_hits", hit_count, 32'd0);
        chk("init_misses", miss_count, 32'd0);

        mem_store[32'h0000_1004] = 32'hDEAD_BEEF;
        do_req(1'b0, 32'h0000_1004, 32'h0, 2);
        chk("cold_rdata", cpu_rdata, 32'hDEAD_BEEF);
        do_req(1'b0, 32'h0000_1004, 32'h0, 2);
        chk("warm_hits", hit_count, 32'd1);

        do_req(1'b1, 32'h0000_1004, 32'h1234_5678, 1);
        do_req(1'b0, 32'h0000_3004, 32'h0, 1);
        chk("evict_store", mem_rd(32'h0000_1004), 32'h1234_5678);

        do_req(1'b1, 32'h0000_0008, 32'hCAFE_F00D, 0);
        do_req(1'b0, 32'h0000_0008, 32'h0, 0);
        chk("wmiss_rdata", cpu_rdata, 32'hCAFE_F00D);

        // Reset while a refill is waiting on memory
        mem_wait = 20;
        txq.delete();
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_5010;
        cnt = 0;
        while (mem_req !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        @(negedge clk);
        chk("mr_req_before", {31'b0, mem_req}, 32'd1);
        reset   = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("mr_req_after", {31'b0, mem_req}, 32'd0);
        chk("mr_ready", {31'b0, cpu_ready}, 32'd0);
        reset = 1'b0;
        cnt = 0;
        pulses = 0;
        while (busy === 1'b1 && cnt < 5000) begin
            if (cpu_ready === 1'b1) pulses++;
            cnt++;
            @(negedge clk);
        end
        chk("mr_init_cycles", cnt, 2048);
        chk("mr_no_ready", pulses, 0);
        model_reset();
        chk("mr_hits", hit_count, 32'd0);
        do_req(1'b0, 32'h0000_5010, 32'h0, 1);
        do_req(1'b0, 32'h0000_1004, 32'h0, 0);

        // Hit counter wrap from all-ones
        @(negedge clk);
        force dut.hit_count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.hit_count_q;
        @(negedge clk);
        chk("wrap_preload", hit_count, 32'hFFFF_FFFF);
        m_hits = 32'hFFFF_FFFF;
        do_req(1'b0, 32'h0000_5010, 32'h0, 0);
        chk("wrap_zero", hit_count, 32'd0);

        for (int i = 0; i < 150; i++) begin
            a = ($urandom_range(0, 3) << 13) | ($urandom_range(0, 3) << 2)
                | $urandom_range(0, 3);
            do_req(1'($urandom_range(0, 1)), a, $urandom,
                   $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
